// File: rtl/debug_disp_pkg.sv
// Shared types for the debug 7-segment display: character codes, FSM states,
// mode-name ROM and active-low glyph patterns (bit order g..a).
package debug_disp_pkg;

  typedef enum logic [4:0] {
    CH_0 = 5'd0, CH_1, CH_2, CH_3, CH_4, CH_5, CH_6, CH_7,
    CH_8, CH_9, CH_A, CH_B, CH_C, CH_D, CH_E, CH_F,
    CH_P, CH_R, CH_I, CH_S, CH_L, CH_G, CH_N, CH_T,
    CH_U, CH_Y, CH_BLANK, CH_DASH
  } char_t;

  typedef enum logic {
    NORMAL = 1'b0,
    BANNER = 1'b1
  } state_t;

  localparam logic [3:0] MODE_MAX = 4'd10;

  // Leftmost character first.
  localparam char_t NAME_ROM [0:10][0:3] = '{
    '{CH_P, CH_C, CH_BLANK, CH_BLANK},
    '{CH_I, CH_R, CH_BLANK, CH_BLANK},
    '{CH_A, CH_BLANK, CH_BLANK, CH_BLANK},
    '{CH_B, CH_BLANK, CH_BLANK, CH_BLANK},
    '{CH_S, CH_P, CH_BLANK, CH_BLANK},
    '{CH_F, CH_L, CH_A, CH_G},
    '{CH_A, CH_D, CH_D, CH_R},
    '{CH_D, CH_A, CH_T, CH_A},
    '{CH_A, CH_L, CH_U, CH_BLANK},
    '{CH_C, CH_Y, CH_C, CH_BLANK},
    '{CH_A, CH_L, CH_L, CH_BLANK}
  };

  localparam logic [6:0] GLY_0     = 7'b1000000;
  localparam logic [6:0] GLY_1     = 7'b1111001;
  localparam logic [6:0] GLY_2     = 7'b0100100;
  localparam logic [6:0] GLY_3     = 7'b0110000;
  localparam logic [6:0] GLY_4     = 7'b0011001;
  localparam logic [6:0] GLY_5     = 7'b0010010;
  localparam logic [6:0] GLY_6     = 7'b0000010;
  localparam logic [6:0] GLY_7     = 7'b1111000;
  localparam logic [6:0] GLY_8     = 7'b0000000;
  localparam logic [6:0] GLY_9     = 7'b0010000;
  localparam logic [6:0] GLY_A     = 7'b0001000;
  localparam logic [6:0] GLY_B     = 7'b0000011;
  localparam logic [6:0] GLY_C     = 7'b1000110;
  localparam logic [6:0] GLY_D     = 7'b0100001;
  localparam logic [6:0] GLY_E     = 7'b0000110;
  localparam logic [6:0] GLY_F     = 7'b0001110;
  localparam logic [6:0] GLY_P     = 7'b0001100;
  localparam logic [6:0] GLY_R     = 7'b0101111;
  localparam logic [6:0] GLY_I     = 7'b1001111;
  localparam logic [6:0] GLY_L     = 7'b1000111;
  localparam logic [6:0] GLY_G     = 7'b1000010;
  localparam logic [6:0] GLY_N     = 7'b0101011;
  localparam logic [6:0] GLY_T     = 7'b0000111;
  localparam logic [6:0] GLY_U     = 7'b1000001;
  localparam logic [6:0] GLY_Y     = 7'b0010001;
  localparam logic [6:0] GLY_BLANK = 7'b1111111;
  localparam logic [6:0] GLY_DASH  = 7'b0111111;

endpackage

// File: rtl/seg_glyph.sv
// Combinational character-code to active-low 7-segment pattern (g..a).
module seg_glyph
  import debug_disp_pkg::*;
(
  input  char_t      ch,
  output logic [6:0] seg
);

  always_comb begin
    seg = GLY_BLANK;
    case (ch)
      CH_0:     seg = GLY_0;
      CH_1:     seg = GLY_1;
      CH_2:     seg = GLY_2;
      CH_3:     seg = GLY_3;
      CH_4:     seg = GLY_4;
      CH_5:     seg = GLY_5;
      CH_6:     seg = GLY_6;
      CH_7:     seg = GLY_7;
      CH_8:     seg = GLY_8;
      CH_9:     seg = GLY_9;
      CH_A:     seg = GLY_A;
      CH_B:     seg = GLY_B;
      CH_C:     seg = GLY_C;
      CH_D:     seg = GLY_D;
      CH_E:     seg = GLY_E;
      CH_F:     seg = GLY_F;
      CH_P:     seg = GLY_P;
      CH_R:     seg = GLY_R;
      CH_I:     seg = GLY_I;
      CH_S:     seg = GLY_5;
      CH_L:     seg = GLY_L;
      CH_G:     seg = GLY_G;
      CH_N:     seg = GLY_N;
      CH_T:     seg = GLY_T;
      CH_U:     seg = GLY_U;
      CH_Y:     seg = GLY_Y;
      CH_DASH:  seg = GLY_DASH;
      default:  seg = GLY_BLANK;
    endcase
  end

endmodule

// File: rtl/debug_seg_display.sv
// 4-digit multiplexed display of the IR debug word / mode mnemonic with a timed
// "Fn<mode>" banner on mode change. Define DEBUG_SEG_ERR_EN for the sticky error dp.
module debug_seg_display
  import debug_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned HOLD_SCANS = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  mode,
  input  logic        showName,
  input  logic        err,
  input  logic [15:0] dataIn,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HW = $clog2(HOLD_SCANS + 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic [1:0]    dig;
  logic [15:0]   data_hold;
  logic [3:0]    mode_prev;
  logic          mode_chg;
  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  char_t         ch;
  logic [6:0]    glyph;
  logic          dp_n;

  assign tick     = (cnt == CW'(SCAN_DIV - 1));
  assign mode_chg = (mode != mode_prev);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Next state: a mode change outranks hold expiry and restarts the hold.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (mode_chg) begin
      state_d = BANNER;
      hold_d  = HW'(HOLD_SCANS);
    end else if (state_q == BANNER && tick) begin
      if (hold_q <= HW'(1)) begin
        state_d = NORMAL;
        hold_d  = '0;
      end else begin
        hold_d = hold_q - HW'(1);
      end
    end
  end

  // Character for the digit latched at this tick; digit 3 reads dataIn
  // directly because that is the sample being captured into data_hold.
  logic [15:0] word;
  logic [3:0]  nib;
  logic [3:0]  units;
  char_t       tens;

  always_comb begin
    word  = (dig == 2'd3) ? dataIn : data_hold;
    case (dig)
      2'd3:    nib = word[15:12];
      2'd2:    nib = word[11:8];
      2'd1:    nib = word[7:4];
      default: nib = word[3:0];
    endcase
    if (mode >= MODE_MAX) begin
      tens  = CH_1;
      units = mode - MODE_MAX;
    end else begin
      tens  = CH_BLANK;
      units = mode;
    end

    ch = CH_BLANK;
    if (state_q == BANNER) begin
      if (mode > MODE_MAX) ch = CH_DASH;
      else begin
        case (dig)
          2'd3:    ch = CH_F;
          2'd2:    ch = CH_N;
          2'd1:    ch = tens;
          default: ch = char_t'({1'b0, units});
        endcase
      end
    end else if (showName) begin
      ch = (mode > MODE_MAX) ? CH_DASH : NAME_ROM[mode][~dig];
    end else begin
      ch = char_t'({1'b0, nib});
    end
  end

  seg_glyph u_glyph (
    .ch  (ch),
    .seg (glyph)
  );

`ifdef DEBUG_SEG_ERR_EN
  logic err_sticky;
  logic show_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= 1'b0;
      show_prev  <= 1'b0;
    end else begin
      show_prev <= showName;
      if (err)                                  err_sticky <= 1'b1;
      else if (mode_chg || showName != show_prev) err_sticky <= 1'b0;
    end
  end

  assign dp_n = ~(err_sticky && dig == 2'd0);
`else
  logic unused_err;
  assign unused_err = err;
  assign dp_n       = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      dig       <= 2'd3;
      data_hold <= '0;
      mode_prev <= '0;
      an        <= '1;
      seg       <= '1;
    end else begin
      mode_prev <= mode;
      if (tick) begin
        cnt <= '0;
        dig <= dig - 2'd1;
        an  <= ~(4'b0001 << dig);
        seg <= {dp_n, glyph};
        if (dig == 2'd3) data_hold <= dataIn;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_debug_seg_display.sv
// Directed-vector bench for debug_seg_display with SCAN_DIV=4, HOLD_SCANS=8.
module tb_debug_seg_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  mode;
  logic        showName;
  logic        err;
  logic [15:0] dataIn;
  logic [7:0]  seg;
  logic [3:0]  an;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned lead   = 4;
  logic [1:0]  nd     = 2'd3;

  localparam logic [6:0] G0  = 7'b1000000;
  localparam logic [6:0] G1  = 7'b1111001;
  localparam logic [6:0] G3  = 7'b0110000;
  localparam logic [6:0] G4  = 7'b0011001;
  localparam logic [6:0] G5  = 7'b0010010;
  localparam logic [6:0] G9  = 7'b0010000;
  localparam logic [6:0] GA  = 7'b0001000;
  localparam logic [6:0] GC  = 7'b1000110;
  localparam logic [6:0] GE  = 7'b0000110;
  localparam logic [6:0] GF  = 7'b0001110;
  localparam logic [6:0] GN  = 7'b0101011;
  localparam logic [6:0] GL  = 7'b1000111;
  localparam logic [6:0] GG  = 7'b1000010;
  localparam logic [6:0] GBL = 7'b1111111;
  localparam logic [6:0] GDS = 7'b0111111;

`ifdef DEBUG_SEG_ERR_EN
  localparam logic ERR_DP = 1'b0;
`else
  localparam logic ERR_DP = 1'b1;
`endif

  always #5 clk = ~clk;

  debug_seg_display #(.SCAN_DIV(4), .HOLD_SCANS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .showName (showName),
    .err      (err),
    .dataIn   (dataIn),
    .seg      (seg),
    .an       (an)
  );

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s digit %0d: got an/seg %h expected %h", tag, nd, got, exp);
    end
  endtask

  task automatic slot();
    repeat (lead) @(posedge clk);
    #1;
    lead = 4;
  endtask

  task automatic run(input string tag, input logic [6:0] g3, input logic [6:0] g2,
                     input logic [6:0] g1, input logic [6:0] g0,
                     input int unsigned n, input logic dp0);
    logic [6:0] g;
    logic       dp;
    for (int unsigned i = 0; i < n; i++) begin
      slot();
      case (nd)
        2'd3:    g = g3;
        2'd2:    g = g2;
        2'd1:    g = g1;
        default: g = g0;
      endcase
      dp = (nd == 2'd0) ? dp0 : 1'b1;
      check(tag, {an, seg}, {~(4'b0001 << nd), dp, g});
      nd = nd - 2'd1;
    end
  endtask

  task automatic skip(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      slot();
      nd = nd - 2'd1;
    end
  endtask

  initial begin
    rst = 1'b1; mode = 4'd0; showName = 1'b0; err = 1'b0; dataIn = 16'hA5C3;
    repeat (3) @(posedge clk);
    #1 check("reset", {an, seg}, 12'hFFF);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("blank_before_tick", {an, seg}, 12'hFFF);
    lead = 1;

    run("hex_A5C3", GA, G5, GC, G3, 4, 1'b1);
    run("hex_A5C3_f2", GA, G5, GC, G3, 3, 1'b1);
    dataIn = 16'h1E04;
    run("no_tear", GA, G5, GC, G3, 1, 1'b1);
    run("hex_1E04", G1, GE, G0, G4, 4, 1'b1);

    mode = 4'd3;
    run("banner_Fn_3", GF, GN, GBL, G3, 7, 1'b1);
    skip(2);
    run("after_banner3", G1, GE, G0, G4, 3, 1'b1);

    mode = 4'd4;
    run("banner_Fn_4", GF, GN, GBL, G4, 5, 1'b1);
    mode = 4'd5;
    run("banner_restart_Fn_5", GF, GN, GBL, G5, 7, 1'b1);
    skip(2);
    run("after_banner5", G1, GE, G0, G4, 2, 1'b1);

    showName = 1'b1;
    run("name_FLAG", GF, GL, GA, GG, 4, 1'b1);

    mode = 4'd12;
    run("banner_mode12", GDS, GDS, GDS, GDS, 4, 1'b1);
    skip(5);
    run("name_mode12", GDS, GDS, GDS, GDS, 3, 1'b1);

    mode = 4'd10;
    run("banner_Fn10", GF, GN, G1, G0, 4, 1'b1);
    skip(5);
    run("name_ALL", GA, GL, GL, GBL, 3, 1'b1);

    err = 1'b1;
    @(posedge clk);
    #1 err = 1'b0;
    lead = 3;
    run("err_dp", GA, GL, GL, GBL, 8, ERR_DP);
    mode = 4'd9;
    run("err_cleared_Fn_9", GF, GN, GBL, G9, 4, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/debug_seg_display.md
# debug_seg_display

Downstream consumer of the IR debug decoder's `mode`, `showName` and `err` outputs. Drives a 4-digit multiplexed common-anode 7-segment display. It shows the selected debug word in hex, or the mnemonic of the current mode. On every mode change it shows a timed mode-number banner.

## Interface
Parameters:
- `SCAN_DIV`, 50000: clk cycles per digit slot (1 ms at 50 MHz); one "tick" per slot.
- `HOLD_SCANS`, 2000: ticks the mode banner stays up (≈2 s).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  4  debug mode from the IR decoder; valid range 0..10.
- `showName`  in  1  level; 1 = show mode mnemonic instead of data.
- `err`  in  1  IR decode error level/pulse.
- `dataIn`  in  16  debug word selected by `mode`, shown in hex.
- `seg`  out  8  active-low segments; [7]=dp, [6:0]=g..a.
- `an`  out  4  active-low digit enables; `an[3]` is the leftmost digit.

## Operation
- Tick generator: counter 0..SCAN_DIV-1, tick on wrap. Digit index counts 3→2→1→0→3, one step per tick.
- Frame latch: `dataIn` is captured into `dataHold` on the tick that starts digit 3. Within a frame, digits always come from one sample, so there is no tearing.
- `modePrev` register: a mode change is `mode != modePrev`, evaluated every cycle.
- States:
  - NORMAL: `showName`=0 shows hex of `dataHold`, digit 3 = [15:12]. `showName`=1 shows the name ROM entry for `mode`.
  - BANNER: shows 'F','n', tens, units of `mode`. Tens is blank when 0, e.g. mode 7 = "Fn 7" and mode 10 = "Fn10".
- Transitions:
  - Any state, on a mode change: go to BANNER and reload the hold counter to HOLD_SCANS. A mode change during BANNER restarts the hold.
  - BANNER: decrement the hold counter per tick; at 0, go to NORMAL.
- Name ROM for modes 0..10: "PC  ","Ir  ","A   ","b   ","SP  ","FLAG","AddR","dAtA","ALU ","CYC ","ALL ". Modes 11..15 show "----" in both names and banner.
- Mode wrap 10→0 or 0→10 is an ordinary mode change.

## Timing
- `seg` and `an` are registered and update only on tick cycles; exactly one `an` bit is low after the first tick.
- Reset values:
  - `an`=4'b1111, `seg`=8'hFF.
  - state NORMAL, digit index 3, tick counter 0, hold counter 0.
  - `modePrev`=0, `dataHold`=0, error sticky 0.
- Mode-change latency: BANNER is entered 1 cycle after `mode` changes. The banner glyph appears at the next tick, i.e. ≤ SCAN_DIV+1 cycles later.
- Banner duration: HOLD_SCANS ticks ±1 tick.
- Simultaneous events:
  - Mode change and hold expiry in the same cycle: the mode change wins and the hold reloads.
  - `showName` toggle during BANNER: no visible effect until NORMAL.
- Reset asserted mid-frame: all state returns to reset values on the next clk edge. The display blanks until the first tick after release.

## Configuration
- `DEBUG_SEG_ERR_EN` defined:
  - `err`=1 on any cycle sets a sticky flag.
  - While the sticky flag is set, dp of digit 0 is lit in every state.
  - The flag is cleared by a mode change or a `showName` edge; set wins over clear in the same cycle.
- Not defined: `err` is ignored, dp is always off (`seg[7]`=1), and no sticky register is built.

## Structure
- Package `debug_disp_pkg`:
  - 5-bit character code enum: hex 0..F, letters, blank, dash.
  - State enum {NORMAL, BANNER}.
  - Name ROM constant array [0:10][4] of char codes.
  - Active-low glyph constants.
- Sub-module `seg_glyph`: combinational char code → 7-bit active-low segment pattern. This is the one natural split; the rest stays in the top.

## Test plan
All scenarios use SCAN_DIV=4 and HOLD_SCANS=8.
- Reset, then `dataIn`=16'hA5C3, mode 0 held: frames show digits A,5,C,3 with `an` 0111,1011,1101,1110; `seg` for 'A'=7'b0001000.
- `mode` 0→3 during frame: BANNER "Fn 3" visible for 8 ticks (±1), then hex data resumes.
- `showName`=1, mode 5, no change: digits show "FLAG"; `mode`=12 shows "----".
- Mode changes 4→5 at tick 5 of the banner: hold restarts; total banner ≈13 ticks, ending with "Fn 5".
- `dataIn` changes mid-frame (during digit 1): current frame unchanged, the new value appears from the next digit-3 slot.
- With DEBUG_SEG_ERR_EN: 1-cycle `err` pulse lights dp on digit 0 (`seg[7]`=0) until the next mode change. Without the macro, `seg[7]` stays 1.
